// File: rtl/regfile_loader.sv
// regfile_loader
//   Streams NREGS register values from a host into an integer register file
//   (x0 .. x(NREGS-1)). It holds the core with busy while loading and pulses
//   done when the frame is complete. A frame that ends early (in_last seen
//   before the final index) still completes, and it raises the sticky err flag.
//
// Ports
//   clock, reset_n        clock (rising edge) and asynchronous active-low reset
//   start                 begin a load sequence (looked at only while idle)
//   in_valid/in_ready     host word handshake
//   in_data, in_last      word for the current index, end-of-frame marker
//   rf_wen/rf_waddr/rf_wdata  registered register-file write port
//   busy                  core hold request (LOAD and DONE)
//   done                  one-cycle pulse in the DONE state
//   err                   sticky short-frame flag, cleared by the next start
//   dbg_state             current FSM state (IDLE=0, LOAD=1, DONE=2)
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the state, never on in_valid, and
// in_valid without in_ready transfers nothing. While loading, the host may
// hold in_valid low for any number of cycles.

module regfile_loader #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_last,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              rf_wen_q, rf_wen_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              err_q, err_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (in_valid) begin
          // x0 is hardwired zero: its word is consumed but never written.
          rf_wen_d   = (idx_q != 5'd0);
          rf_waddr_d = idx_q;
          rf_wdata_d = in_data;
          if (idx_q == LAST_IDX) begin
            // Complete frame; in_last on the final word is irrelevant.
            state_d = DONE;
          end else if (in_last) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_loader.sv
module tb_regfile_loader;

  localparam int NREGS = 32;
  localparam int XLEN  = 64;

  // ---------------------------------------------------------------- clock/reset
  logic            clock;
  logic            reset_n;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_data;
  logic            in_last;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  regfile_loader #(.NREGS(NREGS), .XLEN(XLEN)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Frame-level view: m_next is the index of the next word the loader wants
  // (-1 when no frame is open); m_done marks the closing cycle of a frame.
  int              m_next  = -1;
  bit              m_done  = 0;
  bit              m_err   = 0;
  bit              m_wen   = 0;
  logic [4:0]      m_waddr = '0;
  logic [XLEN-1:0] m_wdata = '0;
  logic [5+XLEN-1:0] exp_q[$];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_next = -1; m_done = 0; m_err = 0; m_wen = 0;
      m_waddr = '0; m_wdata = '0;
      exp_q.delete();
    end else begin
      m_wen = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_next < 0) begin
        if (start) begin
          m_next = 0;
          m_err  = 0;
        end
      end else if (in_valid) begin
        m_waddr = 5'(m_next);
        m_wdata = in_data;
        if (m_next != 0) begin
          m_wen = 1;
          exp_q.push_back({5'(m_next), in_data});
        end
        if (m_next == NREGS - 1) begin
          m_done = 1; m_next = -1;
        end else if (in_last) begin
          m_done = 1; m_err = 1; m_next = -1;
        end else begin
          m_next = m_next + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard / compare
  int              wlog[$];
  logic [XLEN-1:0] wdata_log [NREGS];
  int              done_cyc     = -1;
  int              busy_low_cyc = -1;
  bit              err_at_done  = 0;
  bit              want_low     = 0;
  int              done_total   = 0;

  always @(negedge clock) begin
    if (reset_n) begin
      chk("in_ready", in_ready, (m_next >= 0));
      chk("busy", busy, (m_next >= 0) || m_done);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("rf_wen", rf_wen, m_wen);
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", 1, 0);
        end else begin
          logic [5+XLEN-1:0] e;
          e = exp_q.pop_front();
          chk("sb_addr", rf_waddr, e[5+XLEN-1:XLEN]);
          chk("sb_data", rf_wdata, e[XLEN-1:0]);
        end
        wlog.push_back(int'(rf_waddr));
        wdata_log[rf_waddr] = rf_wdata;
      end
      if (done) begin
        done_cyc = cyc; err_at_done = err; done_total++; want_low = 1;
      end else if (want_low && !busy) begin
        busy_low_cyc = cyc; want_low = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  int t_start, last_hs_cyc;
  bit err_after_start;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Runs one frame. Call at posedge+1 with the loader idle.
  // last_at < 0: full frame; stall_mode 0 none, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int last_at, input int stall_mode, input bit hold_start,
                           input bit rnd_data, input bit ones0);
    int n, w, spins;
    bit took;
    wlog.delete();
    done_cyc = -1; busy_low_cyc = -1;
    start = 1; t_start = cyc;
    tick();
    err_after_start = err;
    if (!hold_start) start = 0;
    n = (last_at >= 0) ? last_at + 1 : NREGS;
    w = 0; spins = 0;
    while (w < n && spins < 1000) begin
      case (stall_mode)
        0: in_valid = 1;
        1: in_valid = (spins % 4 == 0) || (spins % 4 == 3);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      if (ones0 && w == 0) in_data = '1;
      else if (rnd_data)   in_data = {$urandom, $urandom};
      else                 in_data = 64'h1000 + 64'(w);
      in_last = (w == last_at) ? 1'b1 : ((w == NREGS - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      took = in_valid && in_ready;
      if (took) last_hs_cyc = cyc;
      tick();
      if (took) begin
        if (ones0 && w == 0) chk("x0_no_wen", rf_wen, 0);
        w++;
      end
      spins++;
    end
    in_valid = 0; in_last = 0; start = 0;
    chk("frame_timeout", (spins < 1000), 1);
    spins = 0;
    while (busy && spins < 100) begin tick(); spins++; end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    int dc0, exp_n;
    bit ok;
    reset_n = 1; start = 0; in_valid = 0; in_data = '0; in_last = 0;
    #1 reset_n = 0;
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_done_err", {done, err}, 0);
    start = 1;
    repeat (3) tick();
    chk("rst_held_busy", busy, 0);
    start = 0;
    reset_n = 1;
    tick();
    chk("post_rst_idle", {busy, in_ready, done}, 0);

    // full back-to-back load
    run_frame(-1, 0, 0, 0, 0);
    chk("full_writes", wlog.size(), NREGS - 1);
    chk("full_first_addr", wlog[0], 1);
    chk("full_x31", wdata_log[31], 64'h101f);
    chk("full_done_lat", done_cyc - t_start, NREGS + 1);
    chk("full_busy_low", busy_low_cyc - t_start, NREGS + 2);
    chk("full_err", err_at_done, 0);

    // stalled load, valid pattern 1,0,0,1
    run_frame(-1, 1, 0, 0, 0);
    ok = (wlog.size() == NREGS - 1);
    foreach (wlog[i]) if (wlog[i] != i + 1) ok = 0;
    chk("stall_order", ok, 1);
    chk("stall_x17", wdata_log[17], 64'h1011);
    chk("stall_done_lat", done_cyc - last_hs_cyc, 1);

    // short frame ending at k=5
    run_frame(5, 0, 0, 0, 0);
    chk("short_writes", wlog.size(), 5);
    chk("short_last_addr", wlog[wlog.size() - 1], 5);
    chk("short_err_at_done", err_at_done, 1);
    chk("short_done_lat", done_cyc - last_hs_cyc, 1);
    repeat (4) tick();
    chk("short_err_sticky", err, 1);

    // start held high through the load; err clears on this start
    dc0 = done_total;
    run_frame(-1, 2, 1, 1, 0);
    chk("err_cleared", err_after_start, 0);
    chk("held_start_one_seq", done_total - dc0, 1);
    repeat (3) tick();
    chk("held_start_idle", busy, 0);
    chk("held_start_no_more", done_total - dc0, 1);

    // reset after word 10
    start = 1; tick(); start = 0;
    in_valid = 1;
    for (int w = 0; w <= 10; w++) begin
      in_data = 64'h2000 + 64'(w);
      tick();
    end
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("midrst_outs", {dbg_state, busy, in_ready, done, err, rf_wen}, 0);
    chk("midrst_waddr", rf_waddr, 0);
    chk("midrst_wdata", rf_wdata, 0);
    ok = 1;
    for (int i = 0; i < 3; i++) begin tick(); if (rf_wen !== 1'b0) ok = 0; end
    chk("midrst_no_wen", ok, 1);
    reset_n = 1;
    tick();
    run_frame(-1, 0, 0, 0, 0);
    chk("after_rst_writes", wlog.size(), NREGS - 1);
    chk("after_rst_lat", done_cyc - t_start, NREGS + 1);

    // all-ones word for x0
    run_frame(-1, 0, 0, 1, 1);
    chk("x0_next_addr", wlog[0], 1);
    chk("x0_writes", wlog.size(), NREGS - 1);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int last_at;
      last_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NREGS - 2)) : -1;
      run_frame(last_at, 2, 1'($urandom_range(0, 1)), 1, 0);
      exp_n = (last_at >= 0) ? last_at : NREGS - 1;
      chk("rnd_writes", wlog.size(), exp_n);
      chk("rnd_err", err_at_done, (last_at >= 0));
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 Parameter NREGS, default 32, number of architectural integer registers to load (x0 through x(NREGS-1)).
REQ-002 Parameter XLEN, default 64, register and data width in bits.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to begin a load sequence; sampled only in IDLE.
REQ-006 in_valid  in  1  host word available on in_data.
REQ-007 in_ready  out  1  loader accepts a word this cycle.
REQ-008 in_data  in  XLEN  register value for the current index.
REQ-009 in_last  in  1  host marks the final word of the frame.
REQ-010 rf_wen  out  1  register-file write enable.
REQ-011 rf_waddr  out  5  register-file write index.
REQ-012 rf_wdata  out  XLEN  register-file write data.
REQ-013 busy  out  1  core hold request; core shall not retire while high.
REQ-014 done  out  1  one-cycle pulse at the end of a load sequence.
REQ-015 err  out  1  sticky short-frame error flag.

Function
REQ-016 The state machine SHALL have three states: IDLE, LOAD and DONE.
REQ-017 IDLE: start=1 -> LOAD next cycle; index counter cleared to 0; err cleared to 0.
REQ-018 LOAD: in_ready=1 combinationally; in_ready=0 in IDLE and DONE.
REQ-019 A word SHALL be accepted only in a cycle where in_valid=1 and in_ready=1 (handshake); in_valid without in_ready consumes nothing.
REQ-020 Handshake at cycle t with index k SHALL drive rf_waddr=k and rf_wdata=in_data at t+1 (all write outputs registered).
REQ-021 rf_wen SHALL be 1 at t+1 only if k!=0; the word for x0 is consumed and never written.
REQ-022 rf_wen SHALL be 0 in every cycle not covered by REQ-020 and REQ-021; rf_waddr and rf_wdata hold their last value.
REQ-023 Index k SHALL increment by 1 per handshake and never wrap; the word count is exactly NREGS.
REQ-024 Handshake with k==NREGS-1 -> DONE at t+1; in_last at that handshake is ignored.
REQ-025 Handshake with in_last=1 and k<NREGS-1 -> DONE at t+1 with err=1; registers >k are not written.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in LOAD and DONE and 0 in IDLE.
REQ-028 start during LOAD or DONE SHALL be ignored.
REQ-029 err SHALL remain set through IDLE until the next accepted start.
REQ-030 Stalls (in_valid=0) of any length in LOAD SHALL be tolerated with no state change.
REQ-031 Minimum sequence latency: start accepted at cycle 0; NREGS back-to-back handshakes in cycles 1..NREGS; done=1 at cycle NREGS+1; busy=0 at cycle NREGS+2.

Reset
REQ-032 With reset_n=0, outputs SHALL take these values immediately, independent of clock: state=IDLE, index=0, rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, done=0, err=0, in_ready=0.
REQ-033 Reset asserted mid-LOAD SHALL abandon the sequence; no further rf_wen pulses occur; writes already issued are not undone.
REQ-034 After reset_n deasserts, the block SHALL act on start no earlier than the first rising edge.

Verification
REQ-035 Full load: start pulse, then 32 back-to-back words of value 0x1000+k -> 31 writes (x1..x31) carrying those values, no write to x0, done at cycle 33, busy low at cycle 34, err=0.
REQ-036 Stalled load: in_valid toggled 1,0,0,1 per cycle -> same 31 writes in order, no duplicate or skipped index, done one cycle after the 32nd handshake.
REQ-037 Short frame: in_last=1 on word k=5 -> writes x1..x5 only, done=1 and err=1 at the next cycle; err stays 1 until the next start, then clears.
REQ-038 Ignored start: start held high throughout LOAD -> exactly one sequence runs, and the block returns to IDLE after done.
REQ-039 Reset mid-load: reset_n driven low after word 10 -> all outputs 0 at once, no rf_wen afterwards; a fresh start then completes a full 32-word load.
REQ-040 x0 word 0xFFFF_FFFF_FFFF_FFFF at k=0 -> rf_wen=0 in the following cycle; the next word writes x1.
